tick_enable_gen: RTL and testbench

TICK_ENABLE_GEN -- requirements
Module: tick_enable_gen

---
 rtl/tick_enable_pkg.sv | 12 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/tick_enable_gen.sv | 115 +++++++++++
 tb/tb_tick_enable_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_enable_pkg.sv
// Shared state type and default widths for the tick enable generator.
package tick_enable_pkg;

  localparam int DEF_DIV_W   = 8;
  localparam int DEF_BURST_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler: counts run cycles and flags a tick when the count
// reaches the live divisor, wrapping back to zero on that same edge.
module tick_prescaler
  import tick_enable_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_pre_cnt;

  // Comparing with >= lets a divisor lowered below the count wrap at once
  // instead of stalling for a full counter roll-over.
  assign tick = run && (r_pre_cnt >= div);

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (clear) begin
      r_pre_cnt <= '0;
    end else if (run) begin
      r_pre_cnt <= tick ? '0 : r_pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_enable_gen.sv
// Tick enable generator: IDLE/RUN controller around a prescaler, emitting a
// registered one-cycle en. Define TICK_BURST_EN to enable bounded bursts.
module tick_enable_gen
  import tick_enable_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  output logic               en,
  output logic               busy,
  output logic               done
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_en;
  logic   w_en_nxt;
  logic   w_run;
  logic   w_clear;
  logic   w_tick;

  assign w_run   = (r_state == RUN);
  assign w_clear = start | stop;

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .run   (w_run),
    .div   (div),
    .tick  (w_tick)
  );

`ifdef TICK_BURST_EN
  // Remaining ticks in the current burst; zero means unbounded.
  logic [BURST_W-1:0] r_burst_left;
  logic [BURST_W-1:0] w_burst_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_last;

  assign w_last = (r_burst_left == BURST_W'(1));
  assign done   = r_done;
`else
  logic w_unused_burst_len;

  assign w_unused_burst_len = ^burst_len;
  assign done               = 1'b0;
`endif

  // NOTE: every next-value gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
`ifdef TICK_BURST_EN
    w_burst_nxt = r_burst_left;
    w_done_nxt  = 1'b0;
`endif
    if (stop) begin
      w_state_nxt = IDLE;
`ifdef TICK_BURST_EN
      // A stop landing on the final burst tick still lets that tick out.
      w_en_nxt    = w_tick && w_last;
      w_burst_nxt = '0;
`endif
    end else if (start) begin
      w_state_nxt = RUN;
`ifdef TICK_BURST_EN
      w_burst_nxt = burst_len;
`endif
    end else if (w_run) begin
      w_en_nxt = w_tick;
`ifdef TICK_BURST_EN
      if (w_tick && w_last) begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_burst_nxt = '0;
      end else if (w_tick && (r_burst_left != '0)) begin
        w_burst_nxt = r_burst_left - 1'b1;
      end
`endif
    end else begin
      w_en_nxt = step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_en         <= 1'b0;
`ifdef TICK_BURST_EN
      r_burst_left <= '0;
      r_done       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_en         <= w_en_nxt;
`ifdef TICK_BURST_EN
      r_burst_left <= w_burst_nxt;
      r_done       <= w_done_nxt;
`endif
    end
  end

  assign en   = r_en;
  assign busy = (r_state == RUN);

endmodule

// File: tb/tb_tick_enable_gen.sv
// Self-checking bench for tick_enable_gen: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model of the command rules.
module tb_tick_enable_gen;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       start     = 1'b0;
  logic       stop      = 1'b0;
  logic       step      = 1'b0;
  logic [7:0] div       = 8'd0;
  logic [3:0] burst_len = 4'd0;
  logic       en;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  // Downstream 4-bit counter enabled by en.
  logic [3:0] dcnt;
  logic       dcnt_clr = 1'b0;

  // Behavioural model state.
  bit   m_run;
  int   m_cnt;
  int   m_left;
  logic m_en, m_busy, m_done;

  tick_enable_gen #(.DIV_W(8), .BURST_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .div       (div),
    .burst_len (burst_len),
    .en        (en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dcnt_clr) dcnt <= 4'd0;
    else if (en)  dcnt <= dcnt + 4'd1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_left = 0;
    m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  // Applies the command rules for one rising edge using the inputs held there.
  task automatic model_edge();
    logic n_en;
    logic n_done;
    int   d;
    n_en = 1'b0; n_done = 1'b0; d = int'(div);
    if (stop) begin
      if (m_run) begin
`ifdef TICK_BURST_EN
        if (m_cnt >= d && m_left == 1) n_en = 1'b1;
`endif
        m_run = 0; m_cnt = 0; m_left = 0;
      end
    end else if (start) begin
      m_run = 1; m_cnt = 0;
`ifdef TICK_BURST_EN
      m_left = int'(burst_len);
`else
      m_left = 0;
`endif
    end else if (m_run) begin
      if (m_cnt >= d) begin
        n_en = 1'b1; m_cnt = 0;
        if (m_left == 1) begin
          n_done = 1'b1; m_run = 0; m_left = 0;
        end else if (m_left > 1) begin
          m_left = m_left - 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (step) begin
      n_en = 1'b1;
    end
    m_en = n_en; m_busy = m_run; m_done = n_done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; div = 8'd0; burst_len = 4'd0;
    repeat (3) cyc();
    n_vec++;
    if ({en, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_asserted en/busy/done got=%b exp=000", {en, busy, done});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_vec++;
      if ({en, busy, done} !== 3'b000) begin
        n_err++; $display("FAIL reset_idle cyc=%0d got=%b exp=000", i, {en, busy, done});
      end
    end
  endtask

  task automatic test_div3();
    logic exp_en;
    div = 8'd3; start = 1'b1; cyc(); start = 1'b0;
    n_vec++;
    if ({en, busy, done} !== 3'b010) begin
      n_err++; $display("FAIL div3_start got=%b exp=010", {en, busy, done});
    end
    for (int j = 1; j <= 13; j++) begin
      cyc();
      exp_en = (j % 4 == 0);
      n_vec++;
      if ({en, busy, done} !== {exp_en, 2'b10}) begin
        n_err++; $display("FAIL div3_tick k+%0d got=%b exp=%b", j, {en, busy, done}, {exp_en, 2'b10});
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if ({en, busy, done} !== 3'b000) begin
        n_err++; $display("FAIL div3_stopped cyc=%0d got=%b exp=000", i, {en, busy, done});
      end
      cyc();
    end
  endtask

  task automatic test_div0_counter();
    div = 8'd0; start = 1'b1; dcnt_clr = 1'b1; cyc(); start = 1'b0; dcnt_clr = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      cyc();
      n_vec++;
      if ({en, busy, done} !== 3'b110 || dcnt !== 4'(j - 1)) begin
        n_err++;
        $display("FAIL div0_run k+%0d got en/busy/done=%b cnt=%0d exp=110 cnt=%0d", j, {en, busy, done}, dcnt, j - 1);
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    n_vec++;
    if ({en, busy, done} !== 3'b000 || dcnt !== 4'd0) begin
      n_err++; $display("FAIL div0_wrap got en/busy/done=%b cnt=%0d exp=000 cnt=0", {en, busy, done}, dcnt);
    end
  endtask

  task automatic test_step();
    logic exp_en;
    step = 1'b1; cyc(); step = 1'b0;
    n_vec++;
    if ({en, busy, done} !== 3'b100) begin
      n_err++; $display("FAIL step_idle got=%b exp=100", {en, busy, done});
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_vec++;
      if ({en, busy, done} !== 3'b000) begin
        n_err++; $display("FAIL step_single cyc=%0d got=%b exp=000", i, {en, busy, done});
      end
    end
    div = 8'd2; start = 1'b1; cyc(); start = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step = 1'($urandom_range(0, 1));
      cyc();
      exp_en = (j % 3 == 0);
      n_vec++;
      if ({en, busy, done} !== {exp_en, 2'b10}) begin
        n_err++; $display("FAIL step_in_run k+%0d got=%b exp=%b", j, {en, busy, done}, {exp_en, 2'b10});
      end
    end
    step = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
    n_vec++;
    if ({en, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL step_stop got=%b exp=000", {en, busy, done});
    end
  endtask

  task automatic test_burst();
    logic exp_en, exp_busy, exp_done;
`ifdef TICK_BURST_EN
    div = 8'd1; burst_len = 4'd5; start = 1'b1; cyc(); start = 1'b0; burst_len = 4'd0;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      exp_en = (j <= 10) && (j % 2 == 0); exp_busy = (j < 10); exp_done = (j == 10);
      n_vec++;
      if ({en, busy, done} !== {exp_en, exp_busy, exp_done}) begin
        n_err++; $display("FAIL burst5 k+%0d got=%b exp=%b", j, {en, busy, done}, {exp_en, exp_busy, exp_done});
      end
    end
    burst_len = 4'd2; start = 1'b1; cyc(); start = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      exp_en = (j == 2);
      n_vec++;
      if ({en, busy, done} !== {exp_en, 2'b10}) begin
        n_err++; $display("FAIL burst2 k+%0d got=%b exp=%b", j, {en, busy, done}, {exp_en, 2'b10});
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    n_vec++;
    if ({en, busy, done} !== 3'b100) begin
      n_err++; $display("FAIL burst_stop_last got=%b exp=100", {en, busy, done});
    end
    burst_len = 4'd0;
`else
    burst_len = 4'd3;
`endif
    // Unbounded run: burst_len 0 with bursts, or any burst_len without them.
    div = 8'd1; start = 1'b1; cyc(); start = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      exp_en = (j % 2 == 0);
      n_vec++;
      if ({en, busy, done} !== {exp_en, 2'b10}) begin
        n_err++; $display("FAIL unbounded k+%0d got=%b exp=%b", j, {en, busy, done}, {exp_en, 2'b10});
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0; burst_len = 4'd0;
    n_vec++;
    if ({en, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL unbounded_stop got=%b exp=000", {en, busy, done});
    end
  endtask

  task automatic test_live_div();
    int   n_en_seen;
    logic exp_en;
    div = 8'd200; start = 1'b1; cyc(); start = 1'b0;
    n_en_seen = 0;
    for (int j = 1; j <= 150; j++) begin
      cyc();
      if (en === 1'b1) n_en_seen++;
    end
    n_vec++;
    if (n_en_seen != 0 || busy !== 1'b1) begin
      n_err++; $display("FAIL live_div_wait got en_count=%0d busy=%b exp en_count=0 busy=1", n_en_seen, busy);
    end
    div = 8'd10;
    cyc();
    n_vec++;
    if ({en, busy, done} !== 3'b110) begin
      n_err++; $display("FAIL live_div_wrap got=%b exp=110", {en, busy, done});
    end
    for (int j = 1; j <= 22; j++) begin
      cyc();
      exp_en = (j % 11 == 0);
      n_vec++;
      if ({en, busy, done} !== {exp_en, 2'b10}) begin
        n_err++; $display("FAIL live_div_period +%0d got=%b exp=%b", j, {en, busy, done}, {exp_en, 2'b10});
      end
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({en, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL async_reset got=%b exp=000", {en, busy, done});
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_vec++;
      if ({en, busy, done} !== 3'b000) begin
        n_err++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=000", i, {en, busy, done});
      end
    end
  endtask

  task automatic test_random();
    start = 1'b0; stop = 1'b0; step = 1'b0; div = 8'd2; burst_len = 4'd0;
    rst = 1'b1; cyc(); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 99) < 6);
      stop  = ($urandom_range(0, 99) < 4);
      step  = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 9) == 0) div = 8'($urandom_range(0, 6));
      burst_len = 4'($urandom_range(0, 4));
      cyc();
      model_edge();
      n_vec++;
      if ({en, busy, done} !== {m_en, m_busy, m_done}) begin
        n_err++; $display("FAIL random cyc=%0d got en/busy/done=%b exp=%b", i, {en, busy, done}, {m_en, m_busy, m_done});
      end
    end
    start = 1'b0; step = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div3();
    test_div0_counter();
    test_step();
    test_burst();
    test_live_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
